// File: rtl/uart_cmd_bridge_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_bridge_if
// Groups the UART byte handshakes, the SDRAM request/response signals and the
// busy flag of uart_cmd_bridge into one bundle.
//   UART rx   : i_rx_data, i_rx_rdy (in)   / o_rx_req (out, pop pulse)
//   UART tx   : i_tx_rdy (in)              / o_tx_data, o_tx_req (out)
//   SDRAM wr  : o_wr_req, o_wr_addr, o_wr_data (out)
//   SDRAM rd  : o_rd_req, o_rd_addr (out)  / i_rd_data, i_rd_rdy (in)
//   status    : o_busy (out)
// modport master : the bridge itself
// modport slave  : the surrounding UART + SDRAM controller (or a bench)
// ---------------------------------------------------------------------------
interface uart_cmd_bridge_if #(
    parameter int IAddrWidth = 22,
    parameter int DataWidth  = 16
);
    logic [7:0]            i_rx_data;
    logic                  i_rx_rdy;
    logic                  o_rx_req;
    logic [7:0]            o_tx_data;
    logic                  o_tx_req;
    logic                  i_tx_rdy;
    logic                  o_wr_req;
    logic [IAddrWidth-1:0] o_wr_addr;
    logic [DataWidth-1:0]  o_wr_data;
    logic                  o_rd_req;
    logic [IAddrWidth-1:0] o_rd_addr;
    logic [DataWidth-1:0]  i_rd_data;
    logic                  i_rd_rdy;
    logic                  o_busy;

    modport master (
        input  i_rx_data, i_rx_rdy, i_tx_rdy, i_rd_data, i_rd_rdy,
        output o_rx_req, o_tx_data, o_tx_req, o_wr_req, o_wr_addr, o_wr_data,
               o_rd_req, o_rd_addr, o_busy
    );

    modport slave (
        output i_rx_data, i_rx_rdy, i_tx_rdy, i_rd_data, i_rd_rdy,
        input  o_rx_req, o_tx_data, o_tx_req, o_wr_req, o_wr_addr, o_wr_data,
               o_rd_req, o_rd_addr, o_busy
    );
endinterface

// File: rtl/uart_cmd_bridge.sv
// ---------------------------------------------------------------------------
// uart_cmd_bridge
// Turns byte frames from a UART into SDRAM word accesses.
//   write : 0x77 A2 A1 A0 D1 D0  -> one SDRAM write, reply 0x6B
//   read  : 0x72 A2 A1 A0        -> one SDRAM read, reply data MSB then LSB
//   other opcode                 -> reply 0x3F
// Ports:
//   i_sys_clk : clock, all logic on the rising edge
//   i_rst     : synchronous active-high reset
//   bus       : uart_cmd_bridge_if.master (UART rx/tx, SDRAM wr/rd, o_busy)
// Build option:
//   UART_CMD_TIMEOUT_EN : when defined, a frame that stalls for TimeoutCycles
//                         clocks inside the address/data bytes is dropped and
//                         answered with 0x3F. Undefined: wait forever.
// ---------------------------------------------------------------------------
module uart_cmd_bridge #(
    parameter int ClockFreq     = 100_000_000,
    parameter int IAddrWidth    = 22,
    parameter int DataWidth     = 16,
    parameter int TimeoutCycles = ClockFreq / 100
) (
    input logic               i_sys_clk,
    input logic               i_rst,
    uart_cmd_bridge_if.master bus
);
    localparam logic [7:0] OpWrite = 8'h77;
    localparam logic [7:0] OpRead  = 8'h72;
    localparam logic [7:0] RspAck  = 8'h6B;
    localparam logic [7:0] RspNak  = 8'h3F;

    typedef enum logic [3:0] {
        IDLE, ADDR, DATA, WR_ISSUE, RD_ISSUE, RD_WAIT, TX_HI, TX_LO, TX_ACK, TX_NAK
    } state_e;

    state_e                state_q, state_d;
    logic                  is_wr_q, is_wr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [IAddrWidth-1:0] addr_q, addr_d;
    logic [7:0]            data_hi_q, data_hi_d;
    logic [DataWidth-1:0]  rd_data_q, rd_data_d;
    logic                  rx_req_q, rx_req_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_req_q, tx_req_d;
    logic                  wr_req_q, wr_req_d;
    logic [IAddrWidth-1:0] wr_addr_q, wr_addr_d;
    logic [DataWidth-1:0]  wr_data_q, wr_data_d;
    logic                  rd_req_q, rd_req_d;
    logic [IAddrWidth-1:0] rd_addr_q, rd_addr_d;
    logic                  busy_q, busy_d;

    logic                  rx_take;   // byte is accepted this cycle
    logic                  tx_go;     // transmitter can take a byte this cycle
    logic [IAddrWidth-1:0] addr_shift;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int ToWidth = $clog2(TimeoutCycles + 1);
    logic [ToWidth-1:0] to_cnt_q, to_cnt_d;
`endif

    // Shifting a byte in and truncating keeps the low IAddrWidth bits of
    // {A2,A1,A0}, so the discarded upper address bits fall off naturally.
    assign addr_shift = IAddrWidth'({addr_q, bus.i_rx_data});

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_hi_d = data_hi_q;
        rd_data_d = rd_data_q;
        tx_data_d = tx_data_q;
        tx_req_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        rx_take   = 1'b0;
        // The strobe/pop registers gate the next cycle, which makes the
        // "ready ignored right after a handshake" rule fall out for free.
        tx_go     = bus.i_tx_rdy && !tx_req_q;
`ifdef UART_CMD_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.i_rx_rdy && !rx_req_q) begin
                    rx_take = 1'b1;
                    cnt_d   = '0;
                    if (bus.i_rx_data == OpWrite) begin
                        is_wr_d = 1'b1;
                        state_d = ADDR;
                    end else if (bus.i_rx_data == OpRead) begin
                        is_wr_d = 1'b0;
                        state_d = ADDR;
                    end else begin
                        state_d = TX_NAK;
                    end
                end
            end
            ADDR: begin
                if (bus.i_rx_rdy && !rx_req_q) begin
                    rx_take = 1'b1;
                    addr_d  = addr_shift;
                    if (cnt_q == 2'd2) begin
                        cnt_d = '0;
                        if (is_wr_q) begin
                            state_d = DATA;
                        end else begin
                            rd_addr_d = addr_shift;
                            state_d   = RD_ISSUE;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
`ifdef UART_CMD_TIMEOUT_EN
                else if (to_cnt_q == ToWidth'(TimeoutCycles - 1)) state_d = TX_NAK;
                else to_cnt_d = to_cnt_q + ToWidth'(1);
`endif
            end
            DATA: begin
                if (bus.i_rx_rdy && !rx_req_q) begin
                    rx_take = 1'b1;
                    if (cnt_q == 2'd1) begin
                        wr_addr_d = addr_q;
                        wr_data_d = DataWidth'({data_hi_q, bus.i_rx_data});
                        state_d   = WR_ISSUE;
                    end else begin
                        data_hi_d = bus.i_rx_data;
                        cnt_d     = 2'd1;
                    end
                end
`ifdef UART_CMD_TIMEOUT_EN
                else if (to_cnt_q == ToWidth'(TimeoutCycles - 1)) state_d = TX_NAK;
                else to_cnt_d = to_cnt_q + ToWidth'(1);
`endif
            end
            WR_ISSUE: state_d = TX_ACK;
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT: begin
                if (bus.i_rd_rdy) begin
                    rd_data_d = bus.i_rd_data;
                    // Send the high byte straight from the SDRAM bus so the
                    // first tx strobe follows i_rd_rdy by a single cycle.
                    if (tx_go) begin
                        tx_data_d = bus.i_rd_data[15:8];
                        tx_req_d  = 1'b1;
                        state_d   = TX_LO;
                    end else begin
                        state_d = TX_HI;
                    end
                end
            end
            TX_HI: if (tx_go) begin
                tx_data_d = rd_data_q[15:8];
                tx_req_d  = 1'b1;
                state_d   = TX_LO;
            end
            TX_LO: if (tx_go) begin
                tx_data_d = rd_data_q[7:0];
                tx_req_d  = 1'b1;
                state_d   = IDLE;
            end
            TX_ACK: if (tx_go) begin
                tx_data_d = RspAck;
                tx_req_d  = 1'b1;
                state_d   = IDLE;
            end
            TX_NAK: if (tx_go) begin
                tx_data_d = RspNak;
                tx_req_d  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        rx_req_d = rx_take;
        // Issue states last exactly one cycle, so these pulses are one cycle
        // wide and can never overlap.
        wr_req_d = (state_d == WR_ISSUE);
        rd_req_d = (state_d == RD_ISSUE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            is_wr_q   <= 1'b0;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_hi_q <= '0;
            rd_data_q <= '0;
            rx_req_q  <= 1'b0;
            tx_data_q <= '0;
            tx_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_hi_q <= data_hi_d;
            rd_data_q <= rd_data_d;
            rx_req_q  <= rx_req_d;
            tx_data_q <= tx_data_d;
            tx_req_q  <= tx_req_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_req_q  <= rd_req_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
`ifdef UART_CMD_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    assign bus.o_rx_req  = rx_req_q;
    assign bus.o_tx_data = tx_data_q;
    assign bus.o_tx_req  = tx_req_q;
    assign bus.o_wr_req  = wr_req_q;
    assign bus.o_wr_addr = wr_addr_q;
    assign bus.o_wr_data = wr_data_q;
    assign bus.o_rd_req  = rd_req_q;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_busy    = busy_q;
endmodule

// File: doc/uart_cmd_bridge.md
UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 SHALL have parameter ClockFreq, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter IAddrWidth, default 22, SDRAM word-address width.
REQ-003 SHALL have parameter DataWidth, default 16, SDRAM data width (fixed at 16 for this protocol).
REQ-004 SHALL have parameter TimeoutCycles, default ClockFreq/100 (10 ms), inter-byte timeout.
REQ-005 i_sys_clk  in  1  single clock; all logic on rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_rx_data  in  8  received UART byte.
REQ-008 i_rx_rdy  in  1  UART holds an unread byte.
REQ-009 o_rx_req  out  1  one-cycle pulse that pops the current rx byte.
REQ-010 o_tx_data  out  8  byte to transmit.
REQ-011 o_tx_req  out  1  one-cycle transmit strobe.
REQ-012 i_tx_rdy  in  1  UART transmitter idle.
REQ-013 o_wr_req / o_wr_addr / o_wr_data  out  1/IAddrWidth/DataWidth  SDRAM write request, address, data.
REQ-014 o_rd_req / o_rd_addr  out  1/IAddrWidth  SDRAM read request, address.
REQ-015 i_rd_data / i_rd_rdy  in  DataWidth/1  SDRAM read data and one-cycle valid.
REQ-016 o_busy  out  1  high whenever FSM is not IDLE.

Function
REQ-017 Write frame SHALL be 0x77, A2, A1, A0, D1, D0; read frame 0x72, A2, A1, A0; multi-byte fields MSB first.
REQ-018 Address SHALL be {A2,A1,A0}[IAddrWidth-1:0]; upper bits are discarded.
REQ-019 Rx pop: when i_rx_rdy && !o_rx_req in a byte-accepting state, latch i_rx_data and pulse o_rx_req for exactly one cycle; i_rx_rdy is ignored in the cycle after a pop.
REQ-020 FSM states: IDLE, ADDR (3-byte counter), DATA (2-byte counter), WR_ISSUE, RD_ISSUE, RD_WAIT, TX_HI, TX_LO, TX_ACK, TX_NAK.
REQ-021 IDLE: pop opcode; 0x77 -> ADDR (write), 0x72 -> ADDR (read), any other value -> TX_NAK.
REQ-022 ADDR after third byte: write -> DATA, read -> RD_ISSUE; DATA after second byte -> WR_ISSUE.
REQ-023 WR_ISSUE: o_wr_req high for exactly one cycle, address/data stable that cycle and held until the next frame; then TX_ACK.
REQ-024 RD_ISSUE: o_rd_req high one cycle; then RD_WAIT until i_rd_rdy, capturing i_rd_data; then TX_HI.
REQ-025 Tx strobe: in a TX state, when i_tx_rdy && !o_tx_req, drive byte and pulse o_tx_req one cycle; i_tx_rdy is ignored in the cycle after the strobe.
REQ-026 TX_HI sends data[15:8] -> TX_LO sends data[7:0] -> IDLE; TX_ACK sends 0x6B -> IDLE; TX_NAK sends 0x3F -> IDLE.
REQ-027 o_wr_req and o_rd_req SHALL never be high in the same cycle; o_rx_req and o_tx_req are independent.
REQ-028 Bytes arriving during WR_ISSUE, RD_*, or TX_* SHALL stay unpopped until IDLE.
REQ-029 Read latency i_rd_rdy -> first o_tx_req SHALL be 1 cycle when i_tx_rdy is high.

Reset
REQ-030 On i_rst: state IDLE; counters, o_rx_req, o_tx_req, o_wr_req, o_rd_req, o_busy = 0; o_tx_data, addresses, data = 0.
REQ-031 Reset asserted mid-frame or mid-read SHALL abandon the frame; a late i_rd_rdy after reset SHALL be ignored.

Configuration
REQ-032 Macro UART_CMD_TIMEOUT_EN defined: in ADDR or DATA, a counter reloads on each pop; if TimeoutCycles elapse with no pop, go to TX_NAK and discard the partial frame.
REQ-033 Macro UART_CMD_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely for bytes.

Verification
REQ-034 Rx 77 00 00 12 AB CD -> one o_wr_req with o_wr_addr=0x000012, o_wr_data=0xABCD; tx 0x6B.
REQ-035 Rx 72 00 00 12; i_rd_data=0xABCD 5 cycles after o_rd_req -> one o_rd_req with addr 0x000012; tx 0xAB then 0xCD.
REQ-036 Rx 72 FF FF FF -> o_rd_addr=0x3FFFFF (upper 2 bits dropped).
REQ-037 Rx 0x41 -> tx 0x3F; no SDRAM request; next valid frame is processed normally.
REQ-038 With UART_CMD_TIMEOUT_EN and TimeoutCycles=100: rx 77 00, then silence -> tx 0x3F 100 cycles after the last pop; without the macro, no tx.
REQ-039 i_rst pulsed after rx 77 00 00 -> all outputs 0, o_busy=0; a fresh 72 frame completes correctly.
